// File: rtl/alu.sv
// Registered 8-bit datapath ALU: arithmetic, logic, equality compare and
// conditional branch, with a sticky equality flag consumed by BRANCH.
module alu #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 6
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic [2:0]        op,
  output logic [WIDTH-1:0]  out,
  output logic              co_flag,
  output logic              eq_flag,
  output logic              branch_flag
);

  typedef enum logic [2:0] {
    OP_NOP    = 3'b000,
    OP_ADD    = 3'b001,
    OP_SUB    = 3'b010,
    OP_AND    = 3'b011,
    OP_NOT    = 3'b100,
    OP_OR     = 3'b101,
    OP_EQ     = 3'b110,
    OP_BRANCH = 3'b111
  } op_e;

  op_e             op_sel;
  logic [WIDTH-1:0] out_d;
  logic             co_d;
  logic             eq_d;
  logic             br_d;
  logic [WIDTH-1:0] addr_ext;
  logic             a_eq_b;

  assign op_sel = op_e'(op);
  assign a_eq_b = (A == B);

  // Zero-extension written this way stays legal when ADDR_W == WIDTH.
  always_comb begin
    addr_ext               = '0;
    addr_ext[ADDR_W-1:0]   = branch_addr;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a variable unassigned and no latch is inferred.
    out_d = '0;
    co_d  = 1'b0;
    br_d  = 1'b0;
    eq_d  = eq_flag;
    case (op_sel)
      OP_NOP:    ;
      OP_ADD:    {co_d, out_d} = {1'b0, A} + {1'b0, B};
      // The extra top bit of the widened difference is exactly the borrow.
      OP_SUB:    {co_d, out_d} = {1'b0, A} - {1'b0, B};
      OP_AND:    out_d = A & B;
      OP_NOT:    out_d = ~A;
      OP_OR:     out_d = A | B;
      OP_EQ: begin
        eq_d     = a_eq_b;
        out_d[0] = a_eq_b;
      end
      OP_BRANCH: begin
        br_d  = eq_flag;
        out_d = eq_flag ? addr_ext : '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out         <= '0;
      co_flag     <= 1'b0;
      eq_flag     <= 1'b0;
      branch_flag <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, e.g. BRANCH sees the eq_flag from the previous edge.
      out         <= out_d;
      co_flag     <= co_d;
      eq_flag     <= eq_d;
      branch_flag <= br_d;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed literal cases plus random traffic
// compared every cycle against an integer-arithmetic reference model.
module tb_alu;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 6;
  localparam int MODV   = 1 << WIDTH;

  logic              CLK;
  logic              RST_N;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  B;
  logic [ADDR_W-1:0] branch_addr;
  logic [2:0]        op;
  logic [WIDTH-1:0]  out;
  logic              co_flag;
  logic              eq_flag;
  logic              branch_flag;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  alu #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .A           (A),
    .B           (B),
    .branch_addr (branch_addr),
    .op          (op),
    .out         (out),
    .co_flag     (co_flag),
    .eq_flag     (eq_flag),
    .branch_flag (branch_flag)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: integer arithmetic straight from the opcode table.
  int m_out;
  bit m_co, m_eq, m_br;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_out <= 0; m_co <= 0; m_eq <= 0; m_br <= 0;
    end else begin
      int a, b, s;
      a = int'(A);
      b = int'(B);
      m_co <= 0;
      m_br <= 0;
      case (op)
        3'd0: m_out <= 0;
        3'd1: begin s = a + b; m_out <= s % MODV; m_co <= (s >= MODV); end
        3'd2: begin m_out <= (a - b + MODV) % MODV; m_co <= (a < b); end
        3'd3: m_out <= int'(A & B);
        3'd4: m_out <= (MODV - 1) - a;
        3'd5: m_out <= int'(A | B);
        3'd6: begin m_eq <= (a == b); m_out <= (a == b) ? 1 : 0; end
        3'd7: begin m_br <= m_eq; m_out <= m_eq ? int'(branch_addr) : 0; end
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (cmp_en) begin
      check("model_out", 32'(out), 32'(m_out));
      check("model_co",  32'(co_flag), 32'(m_co));
      check("model_eq",  32'(eq_flag), 32'(m_eq));
      check("model_br",  32'(branch_flag), 32'(m_br));
    end
  end

  task automatic do_op(input logic [2:0] o, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [ADDR_W-1:0] ad);
    op = o; A = a; B = b; branch_addr = ad;
    @(posedge CLK);
    #1;
  endtask

  // Literal expectation, applied to both the DUT and the model.
  task automatic expect_all(input string name, input int e_out, input bit e_co,
                            input bit e_eq, input bit e_br);
    check({name, "_out"}, 32'(out), 32'(e_out));
    check({name, "_co"},  32'(co_flag), 32'(e_co));
    check({name, "_eq"},  32'(eq_flag), 32'(e_eq));
    check({name, "_br"},  32'(branch_flag), 32'(e_br));
    check({name, "_model_out"}, 32'(m_out), 32'(e_out));
  endtask

  initial begin
    RST_N = 1'b0; op = 3'd0; A = '0; B = '0; branch_addr = '0;
    #12;
    expect_all("reset_init", 0, 0, 0, 0);
    op = 3'd1; A = 8'hFF; B = 8'hFF;
    #5 RST_N = 1'b1;
    cmp_en = 1'b1;
    @(posedge CLK); #1;
    expect_all("add_ff_ff_pre", 8'hFE, 1, 0, 0);

    // Asynchronous reset mid-cycle: outputs clear without a clock edge.
    RST_N = 1'b0;
    #1;
    expect_all("async_reset", 0, 0, 0, 0);
    #2 RST_N = 1'b1;
    @(posedge CLK); #1;
    expect_all("reset_release", 8'hFE, 1, 0, 0);

    do_op(3'd1, 8'd18,  8'd3,   '0); expect_all("add_18_3",   21,  0, 0, 0);
    do_op(3'd1, 8'd255, 8'd255, '0); expect_all("add_255_255", 254, 1, 0, 0);
    do_op(3'd1, 8'd0,   8'd1,   '0); expect_all("add_0_1",    1,   0, 0, 0);
    do_op(3'd2, 8'd0,   8'd7,   '0); expect_all("sub_0_7",    249, 1, 0, 0);
    do_op(3'd2, 8'd7,   8'd7,   '0); expect_all("sub_7_7",    0,   0, 0, 0);
    do_op(3'd3, 8'b00000101, 8'b00010101, '0); expect_all("and_5_21", 8'b00000101, 0, 0, 0);
    do_op(3'd3, 8'h00, 8'hFF, '0); expect_all("and_0_ff",  8'h00, 0, 0, 0);
    do_op(3'd3, 8'hFF, 8'hFF, '0); expect_all("and_ff_ff", 8'hFF, 0, 0, 0);
    do_op(3'd4, 8'h00, 8'h5A, '0); expect_all("not_0",     8'hFF, 0, 0, 0);
    do_op(3'd5, 8'b10101, 8'b11, '0); expect_all("or_21_3", 8'b10111, 0, 0, 0);
    do_op(3'd5, 8'hFF, 8'h00, '0); expect_all("or_ff_0",   8'hFF, 0, 0, 0);
    do_op(3'd0, 8'h12, 8'h34, '0); expect_all("nop",       0, 0, 0, 0);

    // Branch taken, eq_flag survives an ADD and repeated branches.
    do_op(3'd6, 8'b10101, 8'b10101, '0);        expect_all("eq_taken",   1, 0, 1, 0);
    do_op(3'd7, 8'h00, 8'h00, 6'b100100);       expect_all("br_taken",   8'b00100100, 0, 1, 1);
    do_op(3'd1, 8'd1, 8'd2, 6'b111111);         expect_all("add_hold1",  3, 0, 1, 0);
    do_op(3'd7, 8'h00, 8'h01, 6'b111111);       expect_all("br_again",   8'h3F, 0, 1, 1);

    // Branch not taken.
    do_op(3'd6, 8'b10111, 8'b10101, '0);        expect_all("eq_ne",      0, 0, 0, 0);
    do_op(3'd1, 8'd5, 8'd5, '0);                expect_all("add_hold0",  10, 0, 0, 0);
    do_op(3'd7, 8'h00, 8'h00, 6'b101100);       expect_all("br_not",     0, 0, 0, 0);

    // Reset between EQ and BRANCH clears the flag.
    do_op(3'd6, 8'h44, 8'h44, '0);              expect_all("eq_pre_rst", 1, 0, 1, 0);
    RST_N = 1'b0; #2 RST_N = 1'b1;
    do_op(3'd7, 8'h00, 8'h00, 6'b010101);       expect_all("br_post_rst", 0, 0, 0, 0);

    // Random traffic; equal operands biased so EQ/BRANCH are exercised both ways.
    for (int i = 0; i < 3000; i++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = WIDTH'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        RST_N = 1'b0; #1 RST_N = 1'b1;
      end
      do_op(3'($urandom_range(0, 7)), ra, rb, ADDR_W'($urandom));
    end

    @(negedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
